// File: rtl/cpu_step_controller.sv
// Step/run/halt controller: turns the divided slow clock, a step button and a run switch
// into single-cycle CPU clock enables in the clk domain, and counts issued steps.

module cpu_step_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic sync_o,
   output logic level_o
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            s1_q, s2_q, level_q;
   logic [DB_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
         if (s2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            level_q <= s2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign sync_o  = s2_q;
   assign level_o = level_q;
endmodule

module cpu_step_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_clk,
   input  logic             btn_step,
   input  logic             sw_run,
   input  logic             halt_req,
   output logic             cpu_ce,
   output logic [1:0]       mode,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);
   typedef enum logic [1:0] {
      PAUSED = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             ce_q, ce_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             slow_s1_q, slow_s2_q, slow_s3_q, tick_q;
   logic             btn_sync, btn_db, run_sync, run_db;
   logic             btn_prev_q, btn_armed_q;
   logic [1:0]       prime_q;
   logic             step_req;

   cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
      .clk(clk), .rst(rst), .raw_i(btn_step), .sync_o(btn_sync), .level_o(btn_db)
   );

   cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clk(clk), .rst(rst), .raw_i(sw_run), .sync_o(run_sync), .level_o(run_db)
   );

   // Steps are armed only once the synchronised button has been seen released after
   // the pipeline has filled, so a button held through reset cannot cause a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slow_s1_q   <= 1'b0;
         slow_s2_q   <= 1'b0;
         slow_s3_q   <= 1'b0;
         tick_q      <= 1'b0;
         btn_prev_q  <= 1'b0;
         btn_armed_q <= 1'b0;
         prime_q     <= '0;
      end else begin
         slow_s1_q  <= slow_clk;
         slow_s2_q  <= slow_s1_q;
         slow_s3_q  <= slow_s2_q;
         tick_q     <= slow_s2_q & ~slow_s3_q;
         btn_prev_q <= btn_db;
         prime_q    <= {prime_q[0], 1'b1};
         if (prime_q[1] && !btn_sync)
            btn_armed_q <= 1'b1;
      end
   end

   assign step_req = btn_db & ~btn_prev_q & btn_armed_q;

   always_comb begin
      state_d = state_q;
      ce_d    = 1'b0;
      case (state_q)
         PAUSED: begin
            if (halt_req)      state_d = HALTED;
            else if (run_db)   state_d = RUN;
            else if (step_req) begin
               state_d = STEP;
               ce_d    = 1'b1;
            end
         end
         STEP:    state_d = halt_req ? HALTED : PAUSED;
         RUN: begin
            if (halt_req)     state_d = HALTED;
            else if (!run_db) state_d = PAUSED;
            else              ce_d    = tick_q;
         end
         HALTED: begin
            if (!run_db && !halt_req) state_d = PAUSED;
         end
         default: state_d = PAUSED;
      endcase
      cnt_d = ce_d ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PAUSED;
         ce_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ce_q    <= ce_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_ce     = ce_q;
   assign mode       = state_q;
   assign halted     = (state_q == HALTED);
   assign step_count = cnt_q;
endmodule

// File: tb/tb_cpu_step_controller.sv
// Randomised bench for cpu_step_controller against a history-queue reference model.
module tb_cpu_step_controller;
   localparam int unsigned DB = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned MP = 0, MR = 1, MS = 2, MH = 3;

   logic          clk = 1'b0;
   logic          rst, slow_clk, btn_step, sw_run, halt_req;
   logic          cpu_ce, halted;
   logic [1:0]    mode;
   logic [CW-1:0] step_count;

   cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk), .btn_step(btn_step), .sw_run(sw_run),
      .halt_req(halt_req), .cpu_ce(cpu_ce), .mode(mode), .halted(halted),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0, checks = 0, ce_seen = 0;
   int unsigned slow_per = 40, slow_ph = 0;
   bit          slow_en = 0;

   // Reference model: raw input histories give the synchroniser delays directly.
   bit          slow_h[$], btn_h[$], run_h[$];
   bit          m_btn_db, m_btn_prev, m_run_db, m_armed, m_ce;
   int unsigned m_btn_run, m_run_run, m_mode, m_cnt, m_edges;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      slow_h.delete(); btn_h.delete(); run_h.delete();
      repeat (4) slow_h.push_back(1'b0);
      repeat (2) begin btn_h.push_back(1'b0); run_h.push_back(1'b0); end
      m_btn_db = 0; m_btn_prev = 0; m_run_db = 0; m_armed = 0; m_ce = 0;
      m_btn_run = 0; m_run_run = 0; m_mode = MP; m_cnt = 0; m_edges = 0;
   endtask

   task automatic debounce(input bit s, inout bit lvl, inout int unsigned run);
      if (s == lvl) run = 0;
      else begin
         run++;
         if (run == DB) begin lvl = s; run = 0; end
      end
   endtask

   task automatic model_edge();
      bit tick, step_req;
      tick     = slow_h[$-2] && !slow_h[$-3];
      step_req = m_btn_db && !m_btn_prev && m_armed;
      m_ce = 0;
      case (m_mode)
         MP: if (halt_req) m_mode = MH;
             else if (m_run_db) m_mode = MR;
             else if (step_req) begin m_mode = MS; m_ce = 1; end
         MS: m_mode = halt_req ? MH : MP;
         MR: if (halt_req) m_mode = MH;
             else if (!m_run_db) m_mode = MP;
             else m_ce = tick;
         default: if (!m_run_db && !halt_req) m_mode = MP;
      endcase
      if (m_ce) m_cnt = (m_cnt + 1) % (1 << CW);
      m_edges++;
      if (m_edges >= 3 && !btn_h[$-1]) m_armed = 1;
      m_btn_prev = m_btn_db;
      debounce(btn_h[$-1], m_btn_db, m_btn_run);
      debounce(run_h[$-1], m_run_db, m_run_run);
      slow_h.push_back(slow_clk); btn_h.push_back(btn_step); run_h.push_back(sw_run);
      if (slow_h.size() > 8) void'(slow_h.pop_front());
      if (btn_h.size() > 8) void'(btn_h.pop_front());
      if (run_h.size() > 8) void'(run_h.pop_front());
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("cpu_ce", 32'(cpu_ce), 32'(m_ce));
      check("mode", 32'(mode), m_mode);
      check("halted", 32'(halted), (m_mode == MH) ? 1 : 0);
      check("step_count", 32'(step_count), m_cnt);
      if (cpu_ce) ce_seen++;
      if (slow_en) begin
         slow_ph  = (slow_ph + 1) % slow_per;
         slow_clk = (slow_ph < slow_per / 2);
      end
   endtask

   task automatic start_slow(input int unsigned per);
      slow_per = per; slow_ph = 0; slow_en = 1; slow_clk = 1'b1;
   endtask

   initial begin
      int unsigned base;
      bit found;
      rst = 1; slow_clk = 0; btn_step = 0; sw_run = 0; halt_req = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ce", 32'(cpu_ce), 0);
      check("rst_mode", 32'(mode), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_count", 32'(step_count), 0);
      @(negedge clk) rst = 0;

      // Idle
      repeat (50) cycle();
      check("idle_pulses", ce_seen, 0);

      // Bouncy press then long hold: one step
      repeat (3) begin
         btn_step = 1; repeat (2) cycle();
         btn_step = 0; repeat (2) cycle();
      end
      btn_step = 1; repeat (20) cycle();
      btn_step = 0; repeat (20) cycle();
      check("step_pulses", ce_seen, 1);
      check("step_count1", 32'(step_count), 1);

      // Free run, 5 slow periods
      sw_run = 1; repeat (10) cycle();
      check("run_mode", 32'(mode), MR);
      base = ce_seen;
      start_slow(40);
      repeat (200) cycle();
      check("run_pulses", ce_seen - base, 5);

      // Halt coinciding with a tick
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (slow_h[$-2] && !slow_h[$-3]) found = 1;
         else cycle();
      end
      check("tick_found", found, 1);
      halt_req = 1; cycle(); halt_req = 0;
      check("halt_ce", 32'(cpu_ce), 0);
      check("halt_mode", 32'(mode), MH);
      base = ce_seen;
      repeat (30) cycle();
      btn_step = 1; repeat (20) cycle();
      btn_step = 0; repeat (60) cycle();
      check("halt_pulses", ce_seen - base, 0);
      sw_run = 0; repeat (12) cycle();
      check("unhalt_mode", 32'(mode), MP);

      // Fast run to wrap the counter
      base = ce_seen;
      start_slow(4);
      sw_run = 1; repeat (90) cycle();
      check("wrap_count", 32'(step_count), (6 + ce_seen - base) % (1 << CW));
      check("wrap_seen", (ce_seen - base) > 10 ? 1 : 0, 1);

      // Reset mid-RUN with slow_clk high
      start_slow(40);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         if (slow_clk && m_mode == MR) found = 1;
      end
      check("run_high", found, 1);
      #3 rst = 1;
      #1;
      check("mid_rst_ce", 32'(cpu_ce), 0);
      check("mid_rst_mode", 32'(mode), 0);
      check("mid_rst_halted", 32'(halted), 0);
      check("mid_rst_count", 32'(step_count), 0);
      slow_en = 0; slow_clk = 1; sw_run = 0; btn_step = 1;
      @(posedge clk);
      m_reset();
      @(negedge clk) rst = 0;
      base = ce_seen;
      repeat (40) cycle();
      check("held_btn_pulses", ce_seen - base, 0);
      check("post_rst_mode", 32'(mode), MP);
      btn_step = 0; repeat (20) cycle();
      btn_step = 1; repeat (20) cycle();
      btn_step = 0; repeat (10) cycle();
      check("rearm_pulses", ce_seen - base, 1);

      // Random mix
      start_slow(2 * $urandom_range(3, 10));
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) sw_run = ~sw_run;
         if ($urandom_range(0, 29) == 0) btn_step = ~btn_step;
         halt_req = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
